execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 147 ++++++++++++++
 tb/tb_execute_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, integer ALU, control-transfer resolution
// against the fetch prediction, and the EX->WB destination register pipeline.
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        pipeline_flush,
    input  logic [31:0] immediate,
    input  logic [6:0]  func7,
    input  logic [2:0]  func3,
    input  logic [6:0]  opcode,
    input  logic        ex_alu_src,
    input  logic        predictedTaken,
    input  logic        invalid_inst,
    input  logic        ex_wb_reg_file,
    input  logic [4:0]  alu_rd,
    input  logic [1:0]  operand_a_forward_cntl,
    input  logic [1:0]  operand_b_forward_cntl,
    input  logic [31:0] data_forward_mem,
    input  logic [31:0] data_forward_wb,
    output logic [31:0] result_alu,
    output logic [31:0] op1_selected,
    output logic [31:0] op2_selected,
    output logic [31:0] pc_jump_addr,
    output logic        jump_en,
    output logic        update_btb,
    output logic [31:0] calc_jump_addr,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_file
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        branch_cond;
    logic        valid;
    logic        taken;
    logic        unused_func7;

    // Only func7[5] distinguishes SUB/SRA; the other bits carry no meaning here.
    assign unused_func7 = ^{func7[6], func7[4:0]};

    assign pc_plus4  = pc + 32'd4;
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign valid     = !pipeline_flush && !invalid_inst;

    // Forwarding muxes; code 11 falls back to the register-file value.
    always_comb begin
        op1_selected = op1;
        op2_selected = op2;
        case (operand_a_forward_cntl)
            2'b01:   op1_selected = data_forward_mem;
            2'b10:   op1_selected = data_forward_wb;
            default: op1_selected = op1;
        endcase
        case (operand_b_forward_cntl)
            2'b01:   op2_selected = data_forward_mem;
            2'b10:   op2_selected = data_forward_wb;
            default: op2_selected = op2;
        endcase
    end

    assign alu_a = op1_selected;
    assign alu_b = ex_alu_src ? immediate : op2_selected;
    assign shamt = alu_b[4:0];

    // ALU result; operation chosen by opcode/func fields, never by ex_alu_src.
    always_comb begin
        result_alu = alu_a + alu_b;
        case (opcode)
            OPC_LUI:   result_alu = immediate;
            OPC_AUIPC: result_alu = pc + immediate;
            OPC_JAL,
            OPC_JALR:  result_alu = pc_plus4;
            OPC_OP,
            OPC_OP_IMM: begin
                case (func3)
                    3'b000: result_alu = (opcode == OPC_OP && func7[5]) ? (alu_a - alu_b)
                                                                       : (alu_a + alu_b);
                    3'b001: result_alu = alu_a << shamt;
                    3'b010: result_alu = {31'd0, ($signed(alu_a) < $signed(alu_b))};
                    3'b011: result_alu = {31'd0, (alu_a < alu_b)};
                    3'b100: result_alu = alu_a ^ alu_b;
                    3'b101: result_alu = func7[5] ? $unsigned($signed(alu_a) >>> shamt)
                                                  : (alu_a >> shamt);
                    3'b110: result_alu = alu_a | alu_b;
                    default: result_alu = alu_a & alu_b;
                endcase
            end
            default:   result_alu = alu_a + alu_b;
        endcase
    end

    // Branch condition evaluated on the forwarded register operands.
    always_comb begin
        branch_cond = 1'b0;
        case (func3)
            3'b000:  branch_cond = (op1_selected == op2_selected);
            3'b001:  branch_cond = (op1_selected != op2_selected);
            3'b100:  branch_cond = ($signed(op1_selected) < $signed(op2_selected));
            3'b101:  branch_cond = ($signed(op1_selected) >= $signed(op2_selected));
            3'b110:  branch_cond = (op1_selected < op2_selected);
            3'b111:  branch_cond = (op1_selected >= op2_selected);
            default: branch_cond = 1'b0;
        endcase
    end

    // Target computation and redirect; JALR always redirects since fetch cannot know its target.
    always_comb begin
        calc_jump_addr = pc + immediate;
        if (is_jalr) begin
            calc_jump_addr = (op1_selected + immediate) & ~32'd1;
        end
        taken        = valid && (is_jal || is_jalr || (is_branch && branch_cond));
        pc_jump_addr = taken ? calc_jump_addr : pc_plus4;
        jump_en      = valid && ((taken != predictedTaken) || is_jalr);
        update_btb   = taken;
    end

    // Destination register pipeline into WB; squashed instructions never write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_rd       <= 5'd0;
            wb_reg_file <= 1'b0;
        end else begin
            wb_rd       <= alu_rd;
            wb_reg_file <= valid && ex_wb_reg_file;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by random
// instructions compared against a behavioural model of the instruction rules.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, op1, op2, immediate, data_forward_mem, data_forward_wb;
    logic        pipeline_flush, ex_alu_src, predictedTaken, invalid_inst, ex_wb_reg_file;
    logic [6:0]  func7, opcode;
    logic [2:0]  func3;
    logic [4:0]  alu_rd;
    logic [1:0]  operand_a_forward_cntl, operand_b_forward_cntl;
    logic [31:0] result_alu, op1_selected, op2_selected, pc_jump_addr, calc_jump_addr;
    logic        jump_en, update_btb, wb_reg_file;
    logic [4:0]  wb_rd;

    int errors = 0;
    int checks = 0;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .op1(op1), .op2(op2),
        .pipeline_flush(pipeline_flush), .immediate(immediate), .func7(func7),
        .func3(func3), .opcode(opcode), .ex_alu_src(ex_alu_src),
        .predictedTaken(predictedTaken), .invalid_inst(invalid_inst),
        .ex_wb_reg_file(ex_wb_reg_file), .alu_rd(alu_rd),
        .operand_a_forward_cntl(operand_a_forward_cntl),
        .operand_b_forward_cntl(operand_b_forward_cntl),
        .data_forward_mem(data_forward_mem), .data_forward_wb(data_forward_wb),
        .result_alu(result_alu), .op1_selected(op1_selected), .op2_selected(op2_selected),
        .pc_jump_addr(pc_jump_addr), .jump_en(jump_en), .update_btb(update_btb),
        .calc_jump_addr(calc_jump_addr), .wb_rd(wb_rd), .wb_reg_file(wb_reg_file)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] c, input logic [31:0] r,
                                        input logic [31:0] m, input logic [31:0] w);
        if (c == 2'd1) return m;
        if (c == 2'd2) return w;
        return r;
    endfunction

    // Reference: compute every combinational output from the current stimulus.
    task automatic check_model(input string tag);
        logic [31:0] a, b, rs2, res, tgt, redirect;
        logic        cond, ok, tk, je;
        int          sh;
        a   = fwd(operand_a_forward_cntl, op1, data_forward_mem, data_forward_wb);
        rs2 = fwd(operand_b_forward_cntl, op2, data_forward_mem, data_forward_wb);
        b   = ex_alu_src ? immediate : rs2;
        sh  = int'(b % 32);
        res = a + b;
        if (opcode == 7'h37) res = immediate;
        else if (opcode == 7'h17) res = pc + immediate;
        else if (opcode == 7'h6F || opcode == 7'h67) res = pc + 4;
        else if (opcode == 7'h33 || opcode == 7'h13) begin
            case (func3)
                3'd0: res = (opcode == 7'h33 && func7[5]) ? a - b : a + b;
                3'd1: res = a << sh;
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = func7[5] ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end
        tgt = (opcode == 7'h67) ? ((a + immediate) & 32'hFFFF_FFFE) : pc + immediate;
        case (func3)
            3'd0: cond = (a == rs2);
            3'd1: cond = (a != rs2);
            3'd4: cond = ($signed(a) < $signed(rs2));
            3'd5: cond = ($signed(a) >= $signed(rs2));
            3'd6: cond = (a < rs2);
            3'd7: cond = (a >= rs2);
            default: cond = 1'b0;
        endcase
        ok = !pipeline_flush && !invalid_inst;
        tk = ok && (opcode == 7'h6F || opcode == 7'h67 || (opcode == 7'h63 && cond));
        redirect = tk ? tgt : pc + 4;
        je = ok && ((tk != predictedTaken) || opcode == 7'h67);
        chk({tag, ".op1_sel"}, op1_selected, a);
        chk({tag, ".op2_sel"}, op2_selected, rs2);
        chk({tag, ".result"}, result_alu, res);
        chk({tag, ".calc"}, calc_jump_addr, tgt);
        chk({tag, ".pcjump"}, pc_jump_addr, redirect);
        chk({tag, ".jump_en"}, {31'd0, jump_en}, {31'd0, je});
        chk({tag, ".btb"}, {31'd0, update_btb}, {31'd0, tk});
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] r;
        logic [4:0]  exp_rd;
        logic        exp_we;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0B};

        rst_n = 1'b0; pc = 32'h100; op1 = 32'h11; op2 = 32'h22; immediate = 32'h0;
        data_forward_mem = 32'hDEAD0001; data_forward_wb = 32'hFEED0002;
        pipeline_flush = 0; ex_alu_src = 0; predictedTaken = 0; invalid_inst = 0;
        ex_wb_reg_file = 1; alu_rd = 5'd5; func7 = 0; func3 = 0; opcode = 7'h13;
        operand_a_forward_cntl = 0; operand_b_forward_cntl = 0;

        @(posedge clk); #1;
        chk("reset.wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset.wb_we", {31'd0, wb_reg_file}, 32'd0);
        rst_n = 1'b1;

        // Forwarding sequence
        chk("fwd00.a", op1_selected, 32'h11);
        chk("fwd00.b", op2_selected, 32'h22);
        operand_a_forward_cntl = 2'b01; operand_b_forward_cntl = 2'b01; #1;
        chk("fwd01.a", op1_selected, 32'hDEAD0001);
        chk("fwd01.b", op2_selected, 32'hDEAD0001);
        operand_a_forward_cntl = 2'b10; operand_b_forward_cntl = 2'b10; #1;
        chk("fwd10.a", op1_selected, 32'hFEED0002);
        chk("fwd10.b", op2_selected, 32'hFEED0002);
        operand_a_forward_cntl = 2'b11; operand_b_forward_cntl = 2'b11; #1;
        chk("fwd11.a", op1_selected, 32'h11);
        chk("fwd11.b", op2_selected, 32'h22);
        operand_a_forward_cntl = 0; operand_b_forward_cntl = 0;

        // OP-IMM ADD with both operand sources
        op1 = 32'h10; op2 = 32'h4; immediate = 32'h20; opcode = 7'h13; func3 = 0; #1;
        chk("addi.reg", result_alu, 32'h14);
        ex_alu_src = 1; #1;
        chk("addi.imm", result_alu, 32'h30);
        ex_alu_src = 0;

        // JAL, mispredicted not-taken
        pc = 32'h100; immediate = 32'h10; opcode = 7'h6F; predictedTaken = 0; #1;
        chk("jal.calc", calc_jump_addr, 32'h110);
        chk("jal.pcjump", pc_jump_addr, 32'h110);
        chk("jal.jump_en", {31'd0, jump_en}, 32'd1);
        chk("jal.btb", {31'd0, update_btb}, 32'd1);
        chk("jal.result", result_alu, 32'h104);

        // BEQ taken and correctly predicted, then squashed
        opcode = 7'h63; func3 = 3'd0; op1 = 32'h55; op2 = 32'h55; predictedTaken = 1; #1;
        chk("beq.jump_en", {31'd0, jump_en}, 32'd0);
        chk("beq.btb", {31'd0, update_btb}, 32'd1);
        pipeline_flush = 1; #1;
        chk("beqflush.jump_en", {31'd0, jump_en}, 32'd0);
        chk("beqflush.btb", {31'd0, update_btb}, 32'd0);
        pipeline_flush = 0;

        // Non-control instruction predicted taken must fall through to pc+4
        opcode = 7'h33; predictedTaken = 1; #1;
        chk("ftaken.jump_en", {31'd0, jump_en}, 32'd1);
        chk("ftaken.pcjump", pc_jump_addr, 32'h104);

        // JALR always redirects, target bit0 cleared
        opcode = 7'h67; op1 = 32'h203; immediate = 32'h0; predictedTaken = 0; #1;
        chk("jalr.calc", calc_jump_addr, 32'h202);
        chk("jalr.jump_en0", {31'd0, jump_en}, 32'd1);
        predictedTaken = 1; #1;
        chk("jalr.jump_en1", {31'd0, jump_en}, 32'd1);

        // Writeback register behaviour
        opcode = 7'h13; predictedTaken = 0; alu_rd = 5'd3; ex_wb_reg_file = 1;
        @(posedge clk); #1;
        chk("wb.rd", {27'd0, wb_rd}, 32'd3);
        chk("wb.we", {31'd0, wb_reg_file}, 32'd1);
        invalid_inst = 1;
        @(posedge clk); #1;
        chk("wbinv.we", {31'd0, wb_reg_file}, 32'd0);
        invalid_inst = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        chk("wbrst.rd", {27'd0, wb_rd}, 32'd0);
        chk("wbrst.we", {31'd0, wb_reg_file}, 32'd0);
        rst_n = 1;

        // Randomised instructions against the model
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            opcode = ops[$urandom_range(0, 9)];
            func3 = r[2:0]; func7 = {1'b0, r[3], 5'd0};
            ex_alu_src = r[4]; predictedTaken = r[5];
            pipeline_flush = (r[9:6] == 4'd0); invalid_inst = (r[13:10] == 4'd0);
            ex_wb_reg_file = r[14]; alu_rd = r[19:15];
            operand_a_forward_cntl = r[21:20]; operand_b_forward_cntl = r[23:22];
            pc = $urandom & 32'hFFFF_FFFC; op1 = $urandom;
            op2 = (r[25:24] == 2'd0) ? op1 : $urandom;
            immediate = r[26] ? $urandom : ($urandom & 32'h0000_001F);
            data_forward_mem = (r[28:27] == 2'd0) ? op1 : $urandom;
            data_forward_wb = $urandom;
            #1;
            check_model("rnd");
            exp_rd = alu_rd;
            exp_we = ex_wb_reg_file && !pipeline_flush && !invalid_inst;
            @(posedge clk); #1;
            chk("rnd.wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
            chk("rnd.wb_we", {31'd0, wb_reg_file}, {31'd0, exp_we});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
